// File: rtl/bitplane_accumulator.sv
// Bit-plane shift-and-add accumulator with a show-ahead result FIFO.
// Takes per-plane ones-counts (MSB plane first) from the thermometer
// encoder, combines IN_BITS planes into one MAC result and queues it.
//
// Handshakes:
//   plane input : a beat transfers on a rising edge where cnt_valid_i and
//                 cnt_ready_o are both high (and start_i/flush_i are low).
//   result out  : the head entry transfers on a rising edge where valid_o
//                 and ready_i are both high (and flush_i is low); data_o is
//                 stable and valid for as long as valid_o is high.
module bitplane_accumulator #(
   parameter int IN_BITS   = 8,
   parameter bit SIGNED_IN = 1'b0,
   parameter int DEPTH     = 4,
   parameter int ACC_W     = IN_BITS + 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     flush_i,
   input  logic                     cnt_valid_i,
   input  logic [3:0]               cnt_i,
   output logic                     cnt_ready_o,
   output logic                     busy_o,
   output logic                     err_o,
   output logic [ACC_W-1:0]         data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PC_W = $clog2(IN_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      PUSH  = 2'd2
   } state_t;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [PC_W-1:0]   plane_cnt;

   logic [ACC_W-1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   logic              cnt_legal;
   logic [ACC_W-1:0]  mag;
   logic [ACC_W-1:0]  term;
   logic [ACC_W-1:0]  acc_nxt;
   logic              last_plane;
   logic              push;
   logic              pop;

   // Status outputs decoded straight from the state register.
   assign cnt_ready_o = (state == ACCUM);
   assign busy_o      = (state != IDLE);

   // FIFO status and show-ahead head.
   assign valid_o = (level_o != '0);
   assign data_o  = mem[rd_ptr];

   // Push only when the FIFO had room at the start of the cycle; a pop in
   // the same cycle does not count as room.
   assign push = (state == PUSH) && (level_o < (AW+1)'(DEPTH));
   assign pop  = valid_o && ready_i;

   assign last_plane = (plane_cnt == PC_W'(IN_BITS - 1));

   // Plane term: illegal counts contribute 0; the MSB plane of a signed
   // vector carries negative weight.
   always_comb begin
      cnt_legal = (cnt_i <= 4'd8);
      mag       = cnt_legal ? ACC_W'(cnt_i) : '0;
      term      = (SIGNED_IN && (plane_cnt == '0)) ? (~mag + 1'b1) : mag;
      acc_nxt   = (acc << 1) + term;
   end

   // Control FSM: accumulate IN_BITS planes, then hand the result to the FIFO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         acc       <= '0;
         plane_cnt <= '0;
         err_o     <= 1'b0;
      end else if (flush_i) begin
         state     <= IDLE;
         acc       <= '0;
         plane_cnt <= '0;
         err_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state     <= ACCUM;
                  acc       <= '0;
                  plane_cnt <= '0;
                  err_o     <= 1'b0;
               end
            end
            ACCUM: begin
               if (start_i) begin
                  // Abort: discard the partial result and any beat this cycle.
                  acc       <= '0;
                  plane_cnt <= '0;
                  err_o     <= 1'b0;
               end else if (cnt_valid_i) begin
                  acc       <= acc_nxt;
                  plane_cnt <= plane_cnt + 1'b1;
                  if (!cnt_legal) begin
                     err_o <= 1'b1;
                  end
                  if (last_plane) begin
                     state <= PUSH;
                  end
               end
            end
            PUSH: begin
               if (push) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result FIFO: circular buffer, pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= acc;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_o <= level_o + 1'b1;
            2'b01:   level_o <= level_o - 1'b1;
            default: level_o <= level_o;
         endcase
      end
   end

endmodule
